vga_timing_gen: RTL and testbench

//  Upstream stage of the text-terminal pipeline. Generates the VGA raster

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_timing_gen_div.sv | 52 +++++
 rtl/vga_timing_gen.sv | 142 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared VGA timing constants for the text-terminal pipeline (640x480@60
//   defaults), the derived line/frame totals, the raster position type and a
//   window-decode helper. Also used by the renderer and cursor blocks.
package vga_timing_pkg;

  localparam int CLK_DIV_DEF   = 4;
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;
  localparam int SYNC_ACT_DEF  = 0;

  localparam int H_TOTAL = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int POS_W = 10;
  typedef logic [POS_W-1:0] pos_t;

  // True when pos lies in the inclusive window [lo, hi].
  function automatic logic in_window(input pos_t pos, input pos_t lo, input pos_t hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_div.sv
// pixel_tick_div
//   Clock-enable divider: counts 0..CLK_DIV-1 and raises a one-clk tick in
//   the clk where the count equals CLK_DIV-1.
// Ports
//   clk_i     system clock
//   rst_ni    synchronous active-low reset
//   tick_d_o  next-state tick (high when the coming edge starts a tick clk)
//   tick_o    registered pixel tick
module pixel_tick_div
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_d_o,
  output logic tick_o
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;
  logic          tick_q;

  // Next divider value; wraps defensively if ever beyond the last count.
  always_comb begin
    div_d = div_q;
    if (div_q >= DIV_LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  // Tick is exposed one edge early so the raster can be registered in step with it.
  assign tick_d_o = (div_d == DIV_LAST);
  assign tick_o   = tick_q;

  // Divider and tick registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d_o;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster generator for the text terminal: h_pos/v_pos counters advanced by
//   a pixel clock-enable, plus sync, video_on and line/frame strobes. All
//   outputs are registered from next-state counter values so they stay
//   cycle-aligned with h_pos/v_pos.
// Ports
//   clk, reset (sync, active-low), pixel_tick, h_pos, v_pos, hsync, vsync,
//   video_on, line_start, frame_start, cursor_blink (blink build only).
// Build option
//   VGA_TIMING_BLINK_EN : adds a 6-bit frame counter and cursor_blink output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int SYNC_ACT  = SYNC_ACT_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic pixel_tick,
  output pos_t h_pos,
  output pos_t v_pos,
  output logic hsync,
  output logic vsync,
  output logic video_on,
  output logic line_start,
`ifdef VGA_TIMING_BLINK_EN
  output logic cursor_blink,
`endif
  output logic frame_start
);

  localparam int H_TOTAL_C = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL_C = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if ((H_TOTAL_C > 1024) || (V_TOTAL_C > 1024)) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 1024");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 2");
  end

  localparam pos_t H_LAST = pos_t'(H_TOTAL_C - 1);
  localparam pos_t V_LAST = pos_t'(V_TOTAL_C - 1);
  localparam pos_t H_VIS  = pos_t'(H_VISIBLE);
  localparam pos_t V_VIS  = pos_t'(V_VISIBLE);
  localparam pos_t HS_LO  = pos_t'(H_VISIBLE + H_FP);
  localparam pos_t HS_HI  = pos_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam pos_t VS_LO  = pos_t'(V_VISIBLE + V_FP);
  localparam pos_t VS_HI  = pos_t'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic SYNC_ON = (SYNC_ACT != 0) ? 1'b1 : 1'b0;

  logic tick_d;
  pos_t h_q, h_d, v_q, v_d;
  logic hsync_q, vsync_q, video_q, line_q, frame_q;
  logic line_d, frame_d;

  pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk_i   (clk),
    .rst_ni  (reset),
    .tick_d_o(tick_d),
    .tick_o  (pixel_tick)
  );

  // Next raster position; the >= compares keep the counters inside 0..TOTAL-1.
  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (tick_d) begin
      if (h_q >= H_LAST) begin
        h_d    = '0;
        line_d = 1'b1;
        if (v_q >= V_LAST) begin
          v_d     = '0;
          frame_d = 1'b1;
        end else begin
          v_d = v_q + pos_t'(1);
        end
      end else begin
        h_d = h_q + pos_t'(1);
      end
    end else begin
      h_d = h_q;
    end
  end

  // Raster counters and decoded outputs, all taken from next-state values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= ~SYNC_ON;
      vsync_q <= ~SYNC_ON;
      video_q <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= in_window(h_d, HS_LO, HS_HI) ? SYNC_ON : ~SYNC_ON;
      vsync_q <= in_window(v_d, VS_LO, VS_HI) ? SYNC_ON : ~SYNC_ON;
      video_q <= (h_d < H_VIS) && (v_d < V_VIS);
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign h_pos       = h_q;
  assign v_pos       = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

`ifdef VGA_TIMING_BLINK_EN
  logic [5:0] frame_cnt_q;

  // Frame counter; bit 5 toggles every 32 frames and drives the cursor blink.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt_q <= 6'd0;
    end else if (frame_d) begin
      frame_cnt_q <= frame_cnt_q + 6'd1;
    end else begin
      frame_cnt_q <= frame_cnt_q;
    end
  end

  assign cursor_blink = frame_cnt_q[5];
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  // Full-width line timing, shortened vertical timing to keep frames short.
  localparam int CD = 4;
  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = 800, VT = 8;

  logic clk = 1'b0;
  logic reset;
  logic pixel_tick, hsync, vsync, video_on, line_start, frame_start;
  pos_t h_pos, v_pos;
`ifdef VGA_TIMING_BLINK_EN
  logic cursor_blink;
  logic b_tick, b_hs, b_vs, b_vid, b_ls, b_fs, b_blink;
  pos_t b_h, b_v;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACT(0)
  ) dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .h_pos(h_pos), .v_pos(v_pos),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .line_start(line_start),
`ifdef VGA_TIMING_BLINK_EN
    .cursor_blink(cursor_blink),
`endif
    .frame_start(frame_start)
  );

`ifdef VGA_TIMING_BLINK_EN
  // Tiny raster: 7x5 pixels, CLK_DIV 2 -> 70 clks per frame.
  vga_timing_gen #(
    .CLK_DIV(2), .H_VISIBLE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_VISIBLE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_ACT(0)
  ) u_blink (
    .clk(clk), .reset(reset), .pixel_tick(b_tick), .h_pos(b_h), .v_pos(b_v),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_vid), .line_start(b_ls),
    .cursor_blink(b_blink), .frame_start(b_fs)
  );
`endif

  int errors = 0;
  int checks = 0;
  int ls_cnt, fs_cnt, fs_first, fs_last, hs_low_l0, ls_l0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_h"}, 32'(h_pos), 32'd0);
    chk({tag, "_v"}, 32'(v_pos), 32'd0);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_video_on"}, 32'(video_on), 32'd0);
    chk({tag, "_tick"}, 32'(pixel_tick), 32'd0);
    chk({tag, "_line_start"}, 32'(line_start), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
`ifdef VGA_TIMING_BLINK_EN
    chk({tag, "_blink"}, 32'(cursor_blink), 32'd0);
`endif
  endtask

  // Checks every clk from reset release: n=1 is the first clk after release.
  // Pixel index advances when (n+1) is a multiple of CD.
  task automatic run_model(input int ncyc);
    int p, h, v;
    logic tk;
    logic [31:0] exp_v, obs_v;
    ls_cnt = 0; fs_cnt = 0; fs_first = 0; fs_last = 0; hs_low_l0 = 0; ls_l0 = 0;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      p  = (n + 1) / CD;
      tk = ((n + 1) % CD) == 0;
      h  = p % HT;
      v  = (p / HT) % VT;
      exp_v = {6'd0, tk, 10'(h), 10'(v),
               !((h >= HV + HF) && (h <= HV + HF + HS - 1)),
               !((v >= VV + VF) && (v <= VV + VF + VS - 1)),
               (h < HV) && (v < VV), tk && (h == 0), tk && (h == 0) && (v == 0)};
      obs_v = {6'd0, pixel_tick, h_pos, v_pos, hsync, vsync, video_on, line_start, frame_start};
      chk($sformatf("raster_n%0d", n), obs_v, exp_v);
      if (line_start) ls_cnt++;
      if (frame_start) begin
        fs_cnt++;
        if (fs_cnt == 1) fs_first = n;
        else fs_last = n;
      end
      if (n <= HT * CD) begin
        if (!hsync) hs_low_l0++;
        if (line_start) ls_l0++;
      end
    end
  endtask

  initial begin
    int w;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");

    // Release; first line, two full frames and a bit.
    reset = 1'b1;
    run_model(51300);
    chk("line_start_per_3200", 32'(ls_l0), 32'd1);
    chk("hsync_low_clks", 32'(hs_low_l0), 32'd384);
    chk("frame_start_count", 32'(fs_cnt), 32'd2);
    chk("frame_first_clk", 32'(fs_first), 32'd25599);
    chk("frame_period", 32'(fs_last - fs_first), 32'd25600);
    chk("line_count", 32'(ls_cnt), 32'd16);

    // Mid-frame reset at (300,2).
    w = 0;
    while (!((h_pos == 10'd300) && (v_pos == 10'd2)) && (w < 30000)) begin
      @(negedge clk);
      w++;
    end
    chk("reach_300_2", 32'(w < 30000), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_state("midreset");
    @(negedge clk);
    reset = 1'b1;
    run_model(4000);
    chk("restart_line_start", 32'(ls_l0), 32'd1);
    chk("restart_no_frame", 32'(fs_cnt), 32'd0);

`ifdef VGA_TIMING_BLINK_EN
    begin
      int frames;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("blink_reset", 32'(b_blink), 32'd0);
      reset = 1'b1;
      frames = 0;
      for (int n = 1; n <= 4600; n++) begin
        @(negedge clk);
        if (b_fs) frames++;
        chk($sformatf("blink_n%0d", n), 32'(b_blink), 32'((frames / 32) % 2));
      end
      chk("blink_frames", 32'(frames), 32'd65);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
